shared_op_arbiter: RTL

Shares one multi-cycle arithmetic operator among NUM_CLIENTS requesters using the dataflow req/ack pulse handshake. A requester holds req with its operands and opcode. The block picks one requester round-robin, latches its inputs, and runs the operation for LATENCY cycles. It then returns a one-cycle ack with the result. It sits between several dataflow nodes and a single expensive unit (e.g. a multiplier) so that the graph needs only one instance of that unit.

---
 rtl/shared_op_arbiter_pkg.sv | 8 +
 rtl/shared_op_arbiter_if.sv | 18 +
 rtl/shared_op_arbiter_rr_picker.sv | 21 ++
 rtl/shared_op_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/shared_op_arbiter_pkg.sv
// shared_op_arbiter_pkg: opcode and FSM state encodings plus grant-index width helper
package shared_op_arbiter_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_PASS = 2'd3} op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;
  function automatic int idw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/shared_op_arbiter_if.sv
// shared_op_arbiter_if: client bus (req/op/a/b in, ack/dout/grant_id/busy/grant_count out); master=clients, slave=arbiter
interface shared_op_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDW = shared_op_arbiter_pkg::idw(NUM_CLIENTS)
) ();
  logic [NUM_CLIENTS-1:0] client_req;
  logic [2*NUM_CLIENTS-1:0] client_op;
  logic [DATA_WIDTH*NUM_CLIENTS-1:0] client_a;
  logic [DATA_WIDTH*NUM_CLIENTS-1:0] client_b;
  logic [NUM_CLIENTS-1:0] client_ack;
  logic [DATA_WIDTH-1:0] dout;
  logic [IDW-1:0] grant_id;
  logic busy;
  logic [31:0] grant_count;
  modport master (output client_req, client_op, client_a, client_b, input client_ack, dout, grant_id, busy, grant_count);
  modport slave (input client_req, client_op, client_a, client_b, output client_ack, dout, grant_id, busy, grant_count);
endinterface

// File: rtl/shared_op_arbiter_rr_picker.sv
// rr_picker: req_i/ptr_i -> found_o/idx_o, first requester at or above ptr_i, wrapping modulo N
module rr_picker #(
  parameter int N = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);
  logic [IDW-1:0] j;
  always_comb begin
    found_o = |req_i;
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr_i) + k) % N);
      idx_o = req_i[j] ? j : idx_o;
    end
  end
endmodule

// File: rtl/shared_op_arbiter.sv
// shared_op_arbiter: clk/rst + slave bus; round-robin shares one LATENCY-cycle add/sub/mul/pass unit among clients
module shared_op_arbiter
  import shared_op_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  shared_op_arbiter_if.slave bus
);
  localparam int IDW = idw(NUM_CLIENTS);
  localparam int CW = $clog2(LATENCY + 1);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [IDW-1:0] ptr_q, ptr_d, gid_q, gid_d, idx;
  logic found, busy_q, busy_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, dout_q, dout_d, res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_CLIENTS-1:0] ack_q, ack_d;
  logic [31:0] gcnt_q, gcnt_d;
  rr_picker #(.N(NUM_CLIENTS), .IDW(IDW)) u_pick (
    .req_i(bus.client_req),
    .ptr_i(ptr_q),
    .found_o(found),
    .idx_o(idx)
  );
  assign res = op_q == OP_ADD ? a_q + b_q :
               op_q == OP_SUB ? a_q - b_q :
               op_q == OP_MUL ? a_q * b_q : a_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    ack_d = '0;
    dout_d = dout_q;
    busy_d = busy_q;
    gcnt_d = gcnt_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = EXEC;
        gid_d = idx;
        op_d = op_e'(bus.client_op[2*idx +: 2]);
        a_d = bus.client_a[DATA_WIDTH*idx +: DATA_WIDTH];
        b_d = bus.client_b[DATA_WIDTH*idx +: DATA_WIDTH];
        cnt_d = CW'(LATENCY);
        busy_d = 1'b1;
      end
      EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
          dout_d = res;
          ack_d = NUM_CLIENTS'(1) << gid_q;
          gcnt_d = gcnt_q + 32'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d = 1'b0;
        ptr_d = gid_q == IDW'(NUM_CLIENTS - 1) ? '0 : gid_q + IDW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gid_q <= '0;
      op_q <= OP_ADD;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      ack_q <= '0;
      dout_q <= '0;
      busy_q <= 1'b0;
      gcnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      dout_q <= dout_d;
      busy_q <= busy_d;
      gcnt_q <= gcnt_d;
    end
  end
  assign bus.client_ack = ack_q;
  assign bus.dout = dout_q;
  assign bus.grant_id = gid_q;
  assign bus.busy = busy_q;
  assign bus.grant_count = gcnt_q;
endmodule
